// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM round-robin scheduler.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_BE_W   = 4;
    localparam int MASTER_ID_W  = 3;
    localparam int AGE_W        = 8;

    // ID 0 means "no master"; masters are numbered from 1.
    typedef logic [MASTER_ID_W-1:0] master_id_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Rotating-priority picker: grants the first set mask bit after the master
// whose ID is ptr_i, wrapping from the highest ID back to ID 1.
module sdram_rr_pick
    import sdram_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] mask_i,
    input  master_id_t   ptr_i,
    output logic [N-1:0] grant_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        // Bit index ptr_i is master ptr_i+1, the first candidate after ptr_i.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) - 1 + k) % N;
            if (!found && mask_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_rr_scheduler.sv
// Single-slot round-robin SDRAM request scheduler with read-in-flight tracking.
// Optional starvation boost is enabled by defining SDRAM_AGE_BOOST_EN.
module sdram_rr_scheduler
    import sdram_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int AGE_LIMIT   = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            mst_request,
    input  logic [NUM_MASTERS-1:0]            mst_write,
    input  logic [NUM_MASTERS-1:0]            mst_burst,
    input  logic [NUM_MASTERS*SDRAM_ADDR_W-1:0] mst_addr,
    input  logic [NUM_MASTERS*SDRAM_BE_W-1:0] mst_byte_enable,
    input  logic [NUM_MASTERS*SDRAM_DATA_W-1:0] mst_wdata,
    output logic [NUM_MASTERS-1:0]            mst_ack,
    output logic [NUM_MASTERS-1:0]            mst_rdvalid,
    output logic [NUM_MASTERS-1:0]            mst_complete,
    output logic [SDRAM_DATA_W-1:0]           mst_rdata,
    output master_id_t                        sdram_req,
    output logic [SDRAM_ADDR_W-1:0]           sdram_addr,
    output logic                              sdram_write,
    output logic                              sdram_burst,
    output logic [SDRAM_BE_W-1:0]             sdram_byte_enable,
    output logic [SDRAM_DATA_W-1:0]           sdram_wdata,
    input  logic                              sdram_ack,
    input  logic [SDRAM_DATA_W-1:0]           sdram_rdata,
    input  master_id_t                        sdram_rdvalid,
    input  logic                              sdram_complete,
    output logic                              sched_error
);

    sched_state_t              state_q, state_d;
    master_id_t                rr_ptr_q, rr_ptr_d;
    master_id_t                slot_id_q;
    logic                      slot_write_q, slot_burst_q;
    logic [SDRAM_ADDR_W-1:0]   slot_addr_q;
    logic [SDRAM_BE_W-1:0]     slot_be_q;
    logic [SDRAM_DATA_W-1:0]   slot_wdata_q;
    logic [NUM_MASTERS-1:0]    inflight_q, inflight_d;
    logic                      err_q, err_d;

    logic [NUM_MASTERS-1:0]    eligible, rr_grant, grant_oh;
    master_id_t                grant_id;
    logic                      grant_valid;
    logic [SDRAM_ADDR_W-1:0]   sel_addr;
    logic [SDRAM_BE_W-1:0]     sel_be;
    logic [SDRAM_DATA_W-1:0]   sel_wdata;
    logic                      sel_write, sel_burst;

    assign eligible = mst_request & ~inflight_q;

    sdram_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .mask_i  (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant)
    );

`ifdef SDRAM_AGE_BOOST_EN
    logic [NUM_MASTERS-1:0] aged;
    logic [NUM_MASTERS-1:0] aged_first;
    logic                   aged_found;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_age
        logic [AGE_W-1:0] age_q;
        always_ff @(posedge clock) begin
            if (!reset) begin
                age_q <= '0;
            end else if (mst_request[gi] && !mst_ack[gi]) begin
                age_q <= (age_q == {AGE_W{1'b1}}) ? age_q : age_q + 8'd1;
            end else begin
                age_q <= '0;
            end
        end
        assign aged[gi] = eligible[gi] && (age_q >= 8'(AGE_LIMIT));
    end

    // Starved masters bypass the rotation; the lowest ID among them wins.
    always_comb begin
        aged_first = '0;
        aged_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!aged_found && aged[i]) begin
                aged_first[i] = 1'b1;
                aged_found    = 1'b1;
            end
        end
        grant_oh = aged_found ? aged_first : rr_grant;
    end
`else
    assign grant_oh = rr_grant;
`endif

    always_comb begin
        grant_id  = '0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        sel_burst = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_oh[i]) begin
                grant_id  = master_id_t'(i + 1);
                sel_addr  = mst_addr[i*SDRAM_ADDR_W +: SDRAM_ADDR_W];
                sel_be    = mst_byte_enable[i*SDRAM_BE_W +: SDRAM_BE_W];
                sel_wdata = mst_wdata[i*SDRAM_DATA_W +: SDRAM_DATA_W];
                sel_write = mst_write[i];
                sel_burst = mst_burst[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reset && (|eligible)) begin
                    grant_valid = 1'b1;
                    state_d     = ST_ISSUE;
                    rr_ptr_d    = grant_id;
                end
            end
            ST_ISSUE: begin
                if (sdram_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mst_ack = grant_valid ? grant_oh : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= master_id_t'(NUM_MASTERS);
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_id_q    <= '0;
            slot_write_q <= 1'b0;
            slot_burst_q <= 1'b0;
        end else if (grant_valid) begin
            slot_id_q    <= grant_id;
            slot_write_q <= sel_write;
            slot_burst_q <= sel_burst;
        end else if (state_q == ST_ISSUE && sdram_ack) begin
            slot_id_q    <= '0;
            slot_write_q <= 1'b0;
            slot_burst_q <= 1'b0;
        end
    end

    // Payload registers need no reset: they are only observed while a slot is valid.
    always_ff @(posedge clock) begin
        if (grant_valid) begin
            slot_addr_q  <= sel_addr;
            slot_be_q    <= sel_be;
            slot_wdata_q <= sel_wdata;
        end
    end

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rdv
        assign mst_rdvalid[gi]  = (sdram_rdvalid == master_id_t'(gi + 1));
        assign mst_complete[gi] = sdram_complete & mst_rdvalid[gi];
    end

    // Clear first, then set, so a same-cycle set/clear leaves the flag set.
    always_comb begin
        inflight_d = inflight_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (mst_complete[i]) begin
                inflight_d[i] = 1'b0;
            end
            if (state_q == ST_ISSUE && sdram_ack && !slot_write_q &&
                slot_id_q == master_id_t'(i + 1)) begin
                inflight_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && sdram_ack) begin
            err_d = 1'b1;
        end
        if (sdram_complete && !(|(mst_rdvalid & inflight_q))) begin
            err_d = 1'b1;
        end
        if (sdram_rdvalid != '0 && int'(sdram_rdvalid) > NUM_MASTERS) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign mst_rdata         = sdram_rdata;
    assign sdram_req         = slot_id_q;
    assign sdram_write       = slot_write_q;
    assign sdram_burst       = slot_burst_q;
    assign sdram_addr        = slot_addr_q;
    assign sdram_byte_enable = slot_be_q;
    assign sdram_wdata       = slot_wdata_q;
    assign sched_error       = err_q;

endmodule

// File: tb/tb_sdram_rr_scheduler.sv
// Directed bench for sdram_rr_scheduler: a cycle-by-cycle vector table plus
// hand-written burst, reset-recovery and starvation sequences.
module tb_sdram_rr_scheduler;
    import sdram_pkg::*;

    localparam int NM = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NM-1:0]         mst_request = '0, mst_write = '0, mst_burst = '0;
    logic [NM*26-1:0]      mst_addr;
    logic [NM*4-1:0]       mst_byte_enable;
    logic [NM*32-1:0]      mst_wdata;
    logic [NM-1:0]         mst_ack, mst_rdvalid, mst_complete;
    logic [31:0]           mst_rdata;
    master_id_t            sdram_req;
    logic [25:0]           sdram_addr;
    logic                  sdram_write, sdram_burst;
    logic [3:0]            sdram_byte_enable;
    logic [31:0]           sdram_wdata;
    logic                  sdram_ack = 1'b0;
    logic [31:0]           sdram_rdata = '0;
    master_id_t            sdram_rdvalid = '0;
    logic                  sdram_complete = 1'b0;
    logic                  sched_error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sdram_rr_scheduler #(.NUM_MASTERS(NM), .AGE_LIMIT(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .mst_request       (mst_request),
        .mst_write         (mst_write),
        .mst_burst         (mst_burst),
        .mst_addr          (mst_addr),
        .mst_byte_enable   (mst_byte_enable),
        .mst_wdata         (mst_wdata),
        .mst_ack           (mst_ack),
        .mst_rdvalid       (mst_rdvalid),
        .mst_complete      (mst_complete),
        .mst_rdata         (mst_rdata),
        .sdram_req         (sdram_req),
        .sdram_addr        (sdram_addr),
        .sdram_write       (sdram_write),
        .sdram_burst       (sdram_burst),
        .sdram_byte_enable (sdram_byte_enable),
        .sdram_wdata       (sdram_wdata),
        .sdram_ack         (sdram_ack),
        .sdram_rdata       (sdram_rdata),
        .sdram_rdvalid     (sdram_rdvalid),
        .sdram_complete    (sdram_complete),
        .sched_error       (sched_error)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req, wr, bst;
        logic       ack, cmp;
        logic [2:0] rdv;
        logic [3:0] e_mack;
        logic [2:0] e_sreq;
        logic       e_swr, e_err;
        logic [3:0] e_mrdv, e_mcmp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] wr, logic [3:0] bst,
                                logic ack, logic cmp, logic [2:0] rdv,
                                logic [3:0] e_mack, logic [2:0] e_sreq, logic e_swr,
                                logic e_err, logic [3:0] e_mrdv, logic [3:0] e_mcmp);
        vec_t v;
        v.rst = rst; v.req = req; v.wr = wr; v.bst = bst;
        v.ack = ack; v.cmp = cmp; v.rdv = rdv;
        v.e_mack = e_mack; v.e_sreq = e_sreq; v.e_swr = e_swr;
        v.e_err = e_err; v.e_mrdv = e_mrdv; v.e_mcmp = e_mcmp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] wr,
                         input logic [3:0] bs, input logic ak, input logic cm,
                         input logic [2:0] rv);
        @(negedge clock);
        reset          = r;
        mst_request    = rq;
        mst_write      = wr;
        mst_burst      = bs;
        sdram_ack      = ak;
        sdram_complete = cm;
        sdram_rdvalid  = rv;
        #1;
    endtask

    logic [3:0] exp_age_pick;

    initial begin
        for (int i = 0; i < NM; i++) begin
            mst_addr[i*26 +: 26]       = 26'h100000 + 26'(i);
            mst_byte_enable[i*4 +: 4]  = 4'h1 << i;
            mst_wdata[i*32 +: 32]      = 32'hA000_0000 + 32'(i);
        end

        //         rst req    wr     bst    ak cm rdv | mack  sreq swr err mrdv   mcmp
        vt.push_back(mk(0, 4'h5, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h5, 4'h0, 4'h0, 0, 0, 0, 4'h1, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h4, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h4, 4'h0, 4'h0, 1, 0, 0, 4'h0, 1, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h4, 4'h0, 4'h0, 0, 0, 0, 4'h4, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 3, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 1, 1, 4'h0, 0, 0, 0, 4'h1, 4'h1));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 1, 3, 4'h0, 0, 0, 0, 4'h4, 4'h4));
        vt.push_back(mk(0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h1, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h2, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h0, 2, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 1, 0, 0, 4'h0, 2, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h4, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h0, 3, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 1, 0, 0, 4'h0, 3, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h8, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h0, 4, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 1, 0, 0, 4'h0, 4, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'h1, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 1, 1, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
        vt.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 1, 4, 4'h0, 0, 0, 0, 4'h8, 4'h8));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
        vt.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 5, 4'h0, 0, 0, 0, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
        vt.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 4'h0));
        vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 4'h0));

        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        chk("reset sdram_req", 32'(sdram_req), 32'd0);
        chk("reset sdram_write", 32'(sdram_write), 32'd0);
        chk("reset sdram_burst", 32'(sdram_burst), 32'd0);
        chk("reset sched_error", 32'(sched_error), 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].req, vt[i].wr, vt[i].bst, vt[i].ack, vt[i].cmp, vt[i].rdv);
            chk($sformatf("row%0d mst_ack", i), 32'(mst_ack), 32'(vt[i].e_mack));
            chk($sformatf("row%0d sdram_req", i), 32'(sdram_req), 32'(vt[i].e_sreq));
            chk($sformatf("row%0d sdram_write", i), 32'(sdram_write), 32'(vt[i].e_swr));
            chk($sformatf("row%0d sched_error", i), 32'(sched_error), 32'(vt[i].e_err));
            chk($sformatf("row%0d mst_rdvalid", i), 32'(mst_rdvalid), 32'(vt[i].e_mrdv));
            chk($sformatf("row%0d mst_complete", i), 32'(mst_complete), 32'(vt[i].e_mcmp));
            $display("row %0d: req=%h ack=%b -> mst_ack=%h sdram_req=%0d err=%b",
                     i, vt[i].req, vt[i].ack, mst_ack, sdram_req, sched_error);
        end

        // Burst read from master 2; its re-request waits for the completion.
        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        drive(1, 4'h2, 4'h0, 4'h2, 0, 0, 0);
        chk("burst grant mst_ack", 32'(mst_ack), 32'h2);
        drive(1, 4'h2, 4'h0, 4'h2, 0, 0, 0);
        chk("burst sdram_req", 32'(sdram_req), 32'd2);
        chk("burst sdram_burst", 32'(sdram_burst), 32'd1);
        chk("burst sdram_addr", 32'(sdram_addr), 32'h100001);
        chk("burst sdram_byte_enable", 32'(sdram_byte_enable), 32'h2);
        chk("burst sdram_wdata", sdram_wdata, 32'hA000_0001);
        drive(1, 4'h2, 4'h0, 4'h2, 1, 0, 0);
        chk("burst ack-cycle mst_ack", 32'(mst_ack), 32'h0);
        for (int k = 0; k < 3; k++) begin
            sdram_rdata = 32'hD000_0000 + 32'(k);
            drive(1, 4'h2, 4'h0, 4'h2, 0, 0, 2);
            chk($sformatf("beat%0d mst_ack", k), 32'(mst_ack), 32'h0);
            chk($sformatf("beat%0d sdram_req", k), 32'(sdram_req), 32'd0);
            chk($sformatf("beat%0d mst_rdvalid", k), 32'(mst_rdvalid), 32'h2);
            chk($sformatf("beat%0d mst_rdata", k), mst_rdata, 32'hD000_0000 + 32'(k));
            $display("burst beat %0d: rdata=%h mst_ack=%h", k, mst_rdata, mst_ack);
        end
        drive(1, 4'h2, 4'h0, 4'h2, 0, 1, 2);
        chk("complete-cycle mst_ack", 32'(mst_ack), 32'h0);
        chk("complete-cycle mst_complete", 32'(mst_complete), 32'h2);
        drive(1, 4'h2, 4'h0, 4'h2, 0, 0, 0);
        chk("after-complete mst_ack", 32'(mst_ack), 32'h2);
        chk("after-complete sched_error", 32'(sched_error), 32'd0);
        $display("burst sequence done: mst_ack=%h err=%b", mst_ack, sched_error);

        // Reset while issuing with a read in flight for master 1.
        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        drive(1, 4'h1, 4'h0, 4'h0, 0, 0, 0);
        chk("rstseq grant1", 32'(mst_ack), 32'h1);
        drive(1, 4'h1, 4'h0, 4'h0, 1, 0, 0);
        chk("rstseq issue1", 32'(sdram_req), 32'd1);
        drive(1, 4'h3, 4'h2, 4'h0, 0, 0, 0);
        chk("rstseq inflight blocks m1", 32'(mst_ack), 32'h2);
        drive(1, 4'h3, 4'h2, 4'h0, 0, 0, 0);
        chk("rstseq issue2", 32'(sdram_req), 32'd2);
        drive(0, 4'h3, 4'h2, 4'h0, 0, 0, 0);
        chk("rstseq no ack in reset", 32'(mst_ack), 32'h0);
        drive(1, 4'h3, 4'h2, 4'h0, 0, 0, 0);
        chk("rstseq sdram_req cleared", 32'(sdram_req), 32'd0);
        chk("rstseq m1 regranted", 32'(mst_ack), 32'h1);
        chk("rstseq no error", 32'(sched_error), 32'd0);
        drive(1, 4'h2, 4'h2, 4'h0, 0, 0, 0);
        chk("rstseq issue m1 read", 32'(sdram_req), 32'd1);
        chk("rstseq m1 read write=0", 32'(sdram_write), 32'd0);
        $display("reset-recovery sequence done: sdram_req=%0d", sdram_req);

        // Master 4 waits through a long issue while rr_ptr points at master 1.
        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        drive(1, 4'h9, 4'h9, 4'h0, 0, 0, 0);
        chk("age grant1", 32'(mst_ack), 32'h1);
        for (int k = 0; k < 4; k++) drive(1, 4'h8, 4'h8, 4'h0, 0, 0, 0);
        drive(1, 4'hA, 4'hA, 4'h0, 1, 0, 0);
        drive(1, 4'hA, 4'hA, 4'h0, 0, 0, 0);
`ifdef SDRAM_AGE_BOOST_EN
        exp_age_pick = 4'h8;
`else
        exp_age_pick = 4'h2;
`endif
        chk("age pick after m1", 32'(mst_ack), 32'(exp_age_pick));
        $display("age sequence: mst_ack=%h", mst_ack);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_rr_scheduler.md
SDRAM_RR_SCHEDULER -- requirements
Module: sdram_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, meaning number of bus masters (legal 2..7; master IDs 1..NUM_MASTERS, ID 0 = idle).
REQ-002 SHALL have parameter AGE_LIMIT, default 64, meaning wait cycles before a master is starved (1..255).
REQ-003 SHALL have port clock, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports mst_request/mst_write/mst_burst, input, NUM_MASTERS each, per-master request and attributes (bit i = master i+1).
REQ-006 SHALL have ports mst_addr input NUM_MASTERS x 26, mst_byte_enable input NUM_MASTERS x 4, mst_wdata input NUM_MASTERS x 32.
REQ-007 SHALL have ports mst_ack, mst_rdvalid, mst_complete, output, NUM_MASTERS each; mst_rdata, output, 32, shared read data.
REQ-008 SHALL have ports sdram_req output 3 (granted master ID), sdram_addr output 26, sdram_write/sdram_burst output 1, sdram_byte_enable output 4, sdram_wdata output 32.
REQ-009 SHALL have ports sdram_ack input 1, sdram_rdata input 32, sdram_rdvalid input 3 (destination ID), sdram_complete input 1.
REQ-010 SHALL have port sched_error, output, 1, sticky protocol-error flag.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (sdram_req==0) and ISSUE (slot holds a granted request); IDLE->ISSUE on grant, ISSUE->IDLE on sdram_ack.
REQ-012 In IDLE, a master is eligible when its mst_request is high and its read-in-flight flag is clear.
REQ-013 Grant SHALL go to the first eligible master after rr_ptr (rotating, wrapping NUM_MASTERS->1); rr_ptr SHALL update to the granted ID on grant.
REQ-014 mst_ack SHALL be combinational, one-hot, high in the IDLE cycle the grant is made; slot registers load the master's attributes on the following edge.
REQ-015 No grant SHALL be made in a cycle where state is ISSUE, including the sdram_ack cycle; next grant earliest one cycle after ack.
REQ-016 Slot outputs SHALL hold stable throughout ISSUE; on sdram_ack sdram_req, sdram_write, sdram_burst clear to 0.
REQ-017 On sdram_ack with sdram_write==0, the in-flight flag of sdram_req SHALL set; it SHALL clear when sdram_complete is high with sdram_rdvalid equal to that ID.
REQ-018 mst_rdvalid[i] SHALL equal (sdram_rdvalid==i+1); mst_complete[i] SHALL equal sdram_complete and mst_rdvalid[i]; mst_rdata SHALL equal sdram_rdata unregistered.
REQ-019 Per-master 8-bit age counter SHALL increment (saturating at 255) each cycle mst_request is high and not acked, and clear on ack or request low.
REQ-020 Simultaneous flag set and clear for the same ID SHALL leave the flag set.
REQ-021 sched_error SHALL set on: sdram_ack in IDLE; sdram_complete for an ID whose flag is clear; sdram_rdvalid outside 1..NUM_MASTERS and nonzero.

Reset
REQ-022 While reset==0: state IDLE, sdram_req=0, sdram_write=0, sdram_burst=0, rr_ptr=NUM_MASTERS (so master 1 first), all in-flight flags and age counters 0, sched_error=0, no mst_ack.
REQ-023 Reset mid-ISSUE or mid-burst SHALL discard the slot and flags without error; sdram_addr/byte_enable/wdata reset values are don't-care.

Configuration
REQ-024 With SDRAM_AGE_BOOST_EN defined, any eligible master with age>=AGE_LIMIT SHALL win over round-robin order (lowest such ID first), rr_ptr updated normally.
REQ-025 Without SDRAM_AGE_BOOST_EN, age counters and AGE_LIMIT SHALL be absent from logic and arbitration is pure round-robin.

Structure
REQ-026 Package sdram_pkg SHALL hold master-ID typedef (3 bits), SDRAM_ADDR_W=26, SDRAM_DATA_W=32, and the FSM state enum.
REQ-027 Eligible-mask rotate-priority pick SHALL be sub-module sdram_rr_pick (mask and pointer in, one-hot grant out, purely combinational).

Verification
REQ-028 After reset, masters 1 and 3 request reads at once -> master 1 acked first, master 3 acked one cycle after sdram_ack, sdram_req 1 then 3.
REQ-029 All four masters request writes continuously, ack 2 cycles after each issue -> grants 1,2,3,4,1 repeating, no master twice before others.
REQ-030 Master 2 burst read issued, re-requests before sdram_complete with rdvalid=2 -> no mst_ack[1] until the cycle after complete.
REQ-031 sdram_ack with sdram_req==0, or sdram_complete with rdvalid=4 and no read in flight -> sched_error=1 and stays 1 until reset.
REQ-032 SDRAM_AGE_BOOST_EN, AGE_LIMIT=4, master 4 held off 4+ cycles while rr_ptr=1 -> master 4 granted next instead of master 2.
REQ-033 reset asserted during ISSUE with read in flight for master 1 -> next cycle sdram_req=0, flags clear, master 1 request acked normally.
